sa_pe_mac: RTL

SA_PE_MAC -- requirements
Module: sa_pe_mac

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_pe_mac_if.sv | 33 +++
 rtl/sa_sat.sv | 29 ++
 rtl/sa_pe_mac.sv | 102 ++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - weight-FSM state type and saturation limit helpers for the systolic PE
package sa_pkg;

  typedef enum logic [1:0] {
    W_EMPTY  = 2'd0,
    W_LOADED = 2'd1,
    W_ARMED  = 2'd2
  } w_state_t;

  // Limits are returned as 64-bit patterns; callers keep the low w bits.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/sa_pe_mac_if.sv
// rtl/sa_pe_mac_if.sv - activation/psum/weight bundle between a PE and its neighbours
interface sa_pe_mac_if #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32
);

  logic signed [MUL_DATAWIDTH-1:0] i_act;
  logic                            i_act_valid;
  logic signed [ADD_DATAWIDTH-1:0] i_psum;
  logic                            i_psum_valid;
  logic signed [MUL_DATAWIDTH-1:0] i_weight;
  logic                            i_w_load;
  logic                            i_w_swap;
  logic                            i_clr_ovf;
  logic signed [MUL_DATAWIDTH-1:0] o_act;
  logic                            o_act_valid;
  logic signed [ADD_DATAWIDTH-1:0] o_psum;
  logic                            o_psum_valid;
  logic                            o_ovf;

  modport master (
    output i_act, i_act_valid, i_psum, i_psum_valid,
    output i_weight, i_w_load, i_w_swap, i_clr_ovf,
    input  o_act, o_act_valid, o_psum, o_psum_valid, o_ovf
  );

  modport slave (
    input  i_act, i_act_valid, i_psum, i_psum_valid,
    input  i_weight, i_w_load, i_w_swap, i_clr_ovf,
    output o_act, o_act_valid, o_psum, o_psum_valid, o_ovf
  );

endinterface

// File: rtl/sa_sat.sv
// rtl/sa_sat.sv - (W+1)-to-W narrowing with overflow flag; clamps when SA_PE_SAT_EN is defined, wraps otherwise
module sa_sat
  import sa_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W:0]   din,
  output logic [W-1:0] dout,
  output logic         ovf
);

  // The extra top bit disagrees with the next one exactly when the sum left the W-bit range.
  assign ovf = din[W] ^ din[W-1];

`ifdef SA_PE_SAT_EN
  localparam logic [W-1:0] MAXV = W'(sat_max(W));
  localparam logic [W-1:0] MINV = W'(sat_min(W));

  always_comb begin
    dout = din[W-1:0];
    if (ovf) begin
      dout = din[W] ? MINV : MAXV;
    end
  end
`else
  assign dout = din[W-1:0];
`endif

endmodule

// File: rtl/sa_pe_mac.sv
// rtl/sa_pe_mac.sv - systolic-array PE: activation pass-through, double-buffered weight, 2-stage MAC
module sa_pe_mac
  import sa_pkg::*;
#(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32
) (
  input  logic    i_clk,
  input  logic    i_rst,
  sa_pe_mac_if.slave bus
);

  localparam int PW = 2 * MUL_DATAWIDTH;

  generate
    if (ADD_DATAWIDTH < PW) begin : g_width_chk
      $error("sa_pe_mac: ADD_DATAWIDTH must be >= 2*MUL_DATAWIDTH");
    end
  endgenerate

  w_state_t state_q, state_d;
  logic signed [MUL_DATAWIDTH-1:0] w_shadow, w_active;
  logic do_swap;

  logic signed [PW-1:0]            prod_d, prod_q;
  logic signed [ADD_DATAWIDTH-1:0] psum_q;
  logic                            v1_q;
  logic        [ADD_DATAWIDTH:0]   sum;
  logic        [ADD_DATAWIDTH-1:0] sat_psum;
  logic                            sum_ovf;

  // A swap needs a valid shadow, unless the new weight is arriving on the same edge.
  assign do_swap = bus.i_w_swap & (bus.i_w_load | (state_q != W_EMPTY));

  always_comb begin
    state_d = state_q;
    if (do_swap) begin
      state_d = W_ARMED;
    end else if (bus.i_w_load && state_q == W_EMPTY) begin
      state_d = W_LOADED;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= W_EMPTY;
      w_shadow <= '0;
      w_active <= '0;
    end else begin
      state_q <= state_d;
      if (bus.i_w_load) begin
        w_shadow <= bus.i_weight;
      end
      if (do_swap) begin
        w_active <= bus.i_w_load ? bus.i_weight : w_shadow;
      end
    end
  end

  assign prod_d = PW'(bus.i_act) * PW'(w_active);

  // Stage 1 samples the pre-edge active weight, so a swap on this edge only affects later operands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_act       <= '0;
      bus.o_act_valid <= 1'b0;
      prod_q          <= '0;
      psum_q          <= '0;
      v1_q            <= 1'b0;
    end else begin
      bus.o_act       <= bus.i_act;
      bus.o_act_valid <= bus.i_act_valid;
      prod_q          <= prod_d;
      psum_q          <= bus.i_psum;
      v1_q            <= bus.i_act_valid & bus.i_psum_valid & (state_q == W_ARMED);
    end
  end

  assign sum = {{(ADD_DATAWIDTH + 1 - PW){prod_q[PW-1]}}, prod_q}
             + {psum_q[ADD_DATAWIDTH-1], psum_q};

  sa_sat #(.W(ADD_DATAWIDTH)) u_sat (
    .din  (sum),
    .dout (sat_psum),
    .ovf  (sum_ovf)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_psum       <= '0;
      bus.o_psum_valid <= 1'b0;
      bus.o_ovf        <= 1'b0;
    end else begin
      if (v1_q) begin
        bus.o_psum <= sat_psum;
      end
      bus.o_psum_valid <= v1_q;
      bus.o_ovf        <= (bus.o_ovf & ~bus.i_clr_ovf) | (v1_q & sum_ovf);
    end
  end

endmodule
